key_expansion: RTL and testbench



---
 rtl/key_expansion.sv | 160 ++++++++++++++++
 tb/tb_key_expansion.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion.sv
// key_expansion: sequential AES-128 key schedule.
//
// Produces round keys 0..NUM_ROUNDS one at a time behind a valid/ready
// handshake. Only the current round key is stored; each accepted key is
// replaced by the next one on the following clock edge.
//
// Handshake: a round key transfers on any rising edge where
// RoundKeyValid_SO and RoundKeyReady_SI are both high. While valid is high
// and ready is low, RoundKey_DO, Round_DO and LastKey_SO hold steady, and
// valid never drops without a transfer.
//
// Ports:
//   Clk_CI            clock, rising edge
//   Rst_RI            asynchronous active-high reset
//   Start_SI          load Key_DI and begin a schedule (only when idle)
//   Key_DI[127:0]     cipher key, w0 in [127:96]
//   Idle_SO           block is idle and will accept Start_SI
//   RoundKeyValid_SO  RoundKey_DO / Round_DO hold a valid round key
//   RoundKeyReady_SI  consumer accepts the current round key
//   RoundKey_DO[127:0] current round key, same word order as Key_DI
//   Round_DO[3:0]     index of the current round key
//   LastKey_SO        current valid key is the final one (round NUM_ROUNDS)

module key_expansion #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         Clk_CI,
  input  logic         Rst_RI,
  input  logic         Start_SI,
  input  logic [127:0] Key_DI,
  output logic         Idle_SO,
  output logic         RoundKeyValid_SO,
  input  logic         RoundKeyReady_SI,
  output logic [127:0] RoundKey_DO,
  output logic [3:0]   Round_DO,
  output logic         LastKey_SO
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t       state;
  logic [127:0] key;
  logic [3:0]   round;
  logic [7:0]   rcon;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [31:0]  t;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic         handshake;
  logic         at_last;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    sbox u_sbox (
      .a (rot_w3[8*i +: 8]),
      .y (sub_w3[8*i +: 8])
    );
  end

  assign t   = sub_w3 ^ {rcon, 24'h000000};
  assign nw0 = w0 ^ t;
  assign nw1 = w1 ^ nw0;
  assign nw2 = w2 ^ nw1;
  assign nw3 = w3 ^ nw2;

  assign handshake = (state == RUN) && RoundKeyReady_SI;
  assign at_last   = (round == LAST_ROUND);

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state <= IDLE;
      key   <= '0;
      round <= '0;
      rcon  <= 8'h01;
    end else begin
      case (state)
        IDLE: begin
          if (Start_SI) begin
            key   <= Key_DI;
            round <= '0;
            rcon  <= 8'h01;
            state <= RUN;
          end
        end
        RUN: begin
          // Start_SI is deliberately ignored here; only reset aborts a schedule.
          if (handshake) begin
            if (at_last) begin
              // Final key consumed: key and round hold, rcon is not advanced.
              state <= IDLE;
            end else begin
              key   <= {nw0, nw1, nw2, nw3};
              round <= round + 4'd1;
              rcon  <= xtime(rcon);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Idle_SO          = (state == IDLE);
  assign RoundKeyValid_SO = (state == RUN);
  assign RoundKey_DO      = key;
  assign Round_DO         = round;
  assign LastKey_SO       = (state == RUN) && at_last;

endmodule

// sbox: combinational AES forward S-box, one byte in, one byte out.
// The table is packed with entry 0x00 in the top byte, so entry x sits at
// bit offset 8*(255-x) = {~x, 3'b000}.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] idx;

  assign idx = {~a, 3'b000};
  assign y   = SBOX_TABLE[idx +: 8];

endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion: directed bench for key_expansion.
// Instance u_dut_a uses the default 10-round schedule, u_dut_b a 3-round
// build. Expected round keys are the published FIPS-197 values and the
// well-known all-zero-key schedule values.

module tb_key_expansion;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT A (NUM_ROUNDS = 10) ----------------
  logic         start_a, ready_a;
  logic [127:0] key_a;
  logic         idle_a, valid_a, last_a;
  logic [127:0] rk_a;
  logic [3:0]   round_a;

  key_expansion #(.NUM_ROUNDS(10)) u_dut_a (
    .Clk_CI           (clk),
    .Rst_RI           (rst),
    .Start_SI         (start_a),
    .Key_DI           (key_a),
    .Idle_SO          (idle_a),
    .RoundKeyValid_SO (valid_a),
    .RoundKeyReady_SI (ready_a),
    .RoundKey_DO      (rk_a),
    .Round_DO         (round_a),
    .LastKey_SO       (last_a)
  );

  // ---------------- DUT B (NUM_ROUNDS = 3) ----------------
  logic         start_b, ready_b;
  logic [127:0] key_b;
  logic         idle_b, valid_b, last_b;
  logic [127:0] rk_b;
  logic [3:0]   round_b;

  key_expansion #(.NUM_ROUNDS(3)) u_dut_b (
    .Clk_CI           (clk),
    .Rst_RI           (rst),
    .Start_SI         (start_b),
    .Key_DI           (key_b),
    .Idle_SO          (idle_b),
    .RoundKeyValid_SO (valid_b),
    .RoundKeyReady_SI (ready_b),
    .RoundKey_DO      (rk_b),
    .Round_DO         (round_b),
    .LastKey_SO       (last_b)
  );

  // ---------------- scoreboard state ----------------
  int           total = 0;
  int           bad   = 0;
  logic [127:0] exp_q[$];
  logic [127:0] fips_rk[0:10];

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] OTHER_KEY = 128'h00112233445566778899aabbccddeeff;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in cycle 1 (round 0 key should be valid).
  task automatic start_a_with(input logic [127:0] k);
    start_a = 1'b1;
    key_a   = k;
    tick();
    start_a = 1'b0;
  endtask

  task automatic load_fips_expectations();
    exp_q.delete();
    for (int i = 0; i <= 10; i++) exp_q.push_back(fips_rk[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a"}, 136'({idle_a, valid_a, rk_a, round_a, last_a}),
          136'({1'b1, 1'b0, 128'h0, 4'h0, 1'b0}));
    check({tag, "_b"}, 136'({idle_b, valid_b, rk_b, round_b, last_b}),
          136'({1'b1, 1'b0, 128'h0, 4'h0, 1'b0}));
  endtask

  // Consumes the queued keys from DUT A. Ready is randomised with the given
  // stall percentage; during stalls the presented key must not move.
  // Optionally pulses Start_SI (with another key) in cycle inject_cyc.
  // Returns the cycle index at which idle is observed.
  task automatic collect_a(input int stall_pct, input int inject_cyc, output int cyc_out);
    int           cyc;
    int           idx;
    logic         rdy;
    logic [127:0] pk;
    logic [3:0]   pr;
    logic [127:0] e;
    cyc = 1;
    idx = 0;
    while (exp_q.size() > 0 && cyc < 300) begin
      start_a = (cyc == inject_cyc);
      if (cyc == inject_cyc) key_a = OTHER_KEY;
      rdy = ($urandom_range(0, 99) >= stall_pct);
      ready_a = rdy;
      check("valid_a", 136'(valid_a), 136'(1'b1));
      if (rdy) begin
        e = exp_q.pop_front();
        check("round_key_a", 136'(rk_a), 136'(e));
        check("round_idx_a", 136'(round_a), 136'(idx));
        check("last_a", 136'(last_a), 136'(idx == 10));
        idx++;
        tick();
      end else begin
        pk = rk_a;
        pr = round_a;
        tick();
        check("stall_hold_a", 136'({valid_a, pr == round_a, rk_a}), 136'({1'b1, 1'b1, pk}));
      end
      cyc++;
    end
    start_a = 1'b0;
    ready_a = 1'b0;
    if (exp_q.size() > 0) begin
      check("collect_timeout_a", 136'(exp_q.size()), 136'(0));
      exp_q.delete();
    end
    check("idle_after_a", 136'({idle_a, valid_a, last_a}), 136'({1'b1, 1'b0, 1'b0}));
    cyc_out = cyc;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;

    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst     = 1'b1;
    start_a = 1'b0; ready_a = 1'b0; key_a = '0;
    start_b = 1'b0; ready_b = 1'b0; key_b = '0;
    tick();
    tick();
    check_reset_outputs("reset_state");
    rst = 1'b0;
    tick();
    check_reset_outputs("post_reset_idle");

    // FIPS key, ready held high: full sequence and latency to idle.
    load_fips_expectations();
    start_a_with(FIPS_KEY);
    collect_a(0, -1, cyc);
    check("latency_idle_a", 136'(cyc), 136'(12));

    // All-zero key, ready high.
    ready_a = 1'b1;
    start_a_with(128'h0);
    check("zero_r0", 136'({round_a, rk_a}), 136'({4'd0, 128'h0}));
    tick();
    check("zero_r1", 136'({round_a, rk_a}), 136'({4'd1, ZERO_R1}));
    for (int i = 0; i < 9; i++) tick();
    check("zero_r10", 136'({last_a, round_a, rk_a}), 136'({1'b1, 4'd10, ZERO_R10}));
    tick();
    check("zero_idle", 136'({idle_a, valid_a}), 136'({1'b1, 1'b0}));
    ready_a = 1'b0;

    // Random stalls: same sequence, outputs frozen while stalled.
    load_fips_expectations();
    start_a_with(FIPS_KEY);
    collect_a(50, -1, cyc);

    // Start pulsed mid-schedule with another key must be ignored.
    load_fips_expectations();
    start_a_with(FIPS_KEY);
    collect_a(0, 3, cyc);

    // Reset at round 5, then restart.
    ready_a = 1'b1;
    start_a_with(FIPS_KEY);
    for (int i = 0; i < 5; i++) tick();
    check("pre_reset_r5", 136'({round_a, rk_a}), 136'({4'd5, fips_rk[5]}));
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("after_mid_reset");
    start_a_with(FIPS_KEY);
    check("restart_r0", 136'({round_a, rk_a}), 136'({4'd0, fips_rk[0]}));
    tick();
    check("restart_r1", 136'({round_a, rk_a}), 136'({4'd1, fips_rk[1]}));
    for (int i = 0; i < 9; i++) tick();
    check("restart_r10", 136'({last_a, round_a, rk_a}), 136'({1'b1, 4'd10, fips_rk[10]}));
    tick();
    check("restart_idle", 136'(idle_a), 136'(1'b1));
    ready_a = 1'b0;

    // NUM_ROUNDS = 3 build with back-to-back start.
    ready_b = 1'b1;
    start_b = 1'b1;
    key_b   = FIPS_KEY;
    tick();
    start_b = 1'b0;
    for (int i = 0; i <= 3; i++) begin
      check("b_round_key", 136'({valid_b, last_b, round_b, rk_b}),
            136'({1'b1, (i == 3), 4'(i), fips_rk[i]}));
      tick();
    end
    check("b_idle", 136'({idle_b, valid_b}), 136'({1'b1, 1'b0}));
    start_b = 1'b1;
    key_b   = 128'h0;
    tick();
    start_b = 1'b0;
    check("b_b2b_r0", 136'({valid_b, round_b, rk_b}), 136'({1'b1, 4'd0, 128'h0}));
    tick();
    check("b_b2b_r1", 136'({round_b, rk_b}), 136'({4'd1, ZERO_R1}));
    tick();
    tick();
    check("b_b2b_last", 136'({last_b, round_b}), 136'({1'b1, 4'd3}));
    tick();
    check("b_b2b_idle", 136'(idle_b), 136'(1'b1));
    ready_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
